// File: rtl/gfg_fb_pkg.sv
// Shared definitions for the frame-buffer raster sequencer: state encoding and
// the default {z, color} pixel layout.
package gfg_fb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRAW,
        ST_RD,
        ST_CMP
    } fb_state_t;

    localparam int DEF_COLOR_DEPTH = 12;
    localparam int DEF_Z_DEPTH     = 2;
    localparam int DEF_FBW         = DEF_COLOR_DEPTH + DEF_Z_DEPTH;
    localparam int Z_MSB           = DEF_FBW - 1;
    localparam int COLOR_MSB       = DEF_COLOR_DEPTH - 1;

    localparam logic [DEF_Z_DEPTH-1:0] CLEAR_Z = '1;

endpackage

// File: rtl/fb_scan_counter.sv
// Raster-order x/y counter: x fastest, wraps at W-1 then steps y. Exposes the
// next position so the owner can register it alongside the step.
module fb_scan_counter #(
    parameter int W = 80,
    parameter int H = 60,
    localparam int XW = $clog2(W),
    localparam int YW = $clog2(H)
) (
    input  logic          i_clk,
    input  logic          i_arst,
    input  logic          i_clear,
    input  logic          i_step,
    output logic [XW-1:0] o_next_x,
    output logic [YW-1:0] o_next_y,
    output logic          o_last
);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_end, y_end;

    assign x_end  = (x == XW'(W - 1));
    assign y_end  = (y == YW'(H - 1));
    assign o_last = x_end && y_end;

    always_comb begin
        o_next_x = x_end ? '0 : x + 1'b1;
        o_next_y = y;
        if (x_end)
            o_next_y = y_end ? '0 : y + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            x <= '0;
            y <= '0;
        end else if (i_clear) begin
            x <= '0;
            y <= '0;
        end else if (i_step) begin
            x <= o_next_x;
            y <= o_next_y;
        end
    end

endmodule

// File: rtl/fb_raster_sequencer.sv
// Owns the rasterizer port of the frame buffer: clears on new_frame, then streams
// pixels. Optional depth test (RD/CMP read-modify-write) under GFG_FB_ZTEST_EN.
module fb_raster_sequencer
    import gfg_fb_pkg::*;
#(
    parameter int HORIZ_RESOLUTION = 80,
    parameter int VERT_RESOLUTION  = 60,
    parameter int COLOR_DEPTH      = DEF_COLOR_DEPTH,
    parameter int Z_DEPTH          = DEF_Z_DEPTH,
    parameter logic [COLOR_DEPTH-1:0] CLEAR_COLOR = '0,
    localparam int HW  = $clog2(HORIZ_RESOLUTION),
    localparam int VW  = $clog2(VERT_RESOLUTION),
    localparam int FBW = COLOR_DEPTH + Z_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_new_frame,
    output logic                   o_raster_in_progress,
    input  logic                   i_px_valid,
    output logic                   o_px_ready,
    input  logic [HW-1:0]          i_px_x,
    input  logic [VW-1:0]          i_px_y,
    input  logic [COLOR_DEPTH-1:0] i_px_color,
    input  logic [Z_DEPTH-1:0]     i_px_z,
    input  logic                   i_frame_done,
    output logic [HW-1:0]          o_fb_horiz_write_addr,
    output logic [VW-1:0]          o_fb_vert_write_addr,
    output logic                   o_fb_write_en,
    output logic [FBW-1:0]         o_fb_write_pixel_data,
    output logic [HW-1:0]          o_fb_horiz_read_addr,
    output logic [VW-1:0]          o_fb_vert_read_addr,
    input  logic [FBW-1:0]         i_fb_read_pixel_data,
    output logic [15:0]            o_z_reject_count
);

    fb_state_t state;
    logic      scan_clear, scan_step, scan_last;
    logic [HW-1:0] scan_nx;
    logic [VW-1:0] scan_ny;
    logic      px_in_range;
    logic      unused_rd_bits;

    assign unused_rd_bits = ^i_fb_read_pixel_data;

    // Widened compare so power-of-two resolutions still reject nothing in range.
    assign px_in_range = ({1'b0, i_px_x} < (HW + 1)'(HORIZ_RESOLUTION)) &&
                         ({1'b0, i_px_y} < (VW + 1)'(VERT_RESOLUTION));

    assign scan_clear = (state == ST_IDLE) && i_new_frame;
    assign scan_step  = (state == ST_CLEAR) && !scan_last;

    fb_scan_counter #(.W(HORIZ_RESOLUTION), .H(VERT_RESOLUTION)) u_scan (
        .i_clk    (i_clk),
        .i_arst   (i_arst),
        .i_clear  (scan_clear),
        .i_step   (scan_step),
        .o_next_x (scan_nx),
        .o_next_y (scan_ny),
        .o_last   (scan_last)
    );

`ifdef GFG_FB_ZTEST_EN
    logic [HW-1:0]          px_x;
    logic [VW-1:0]          px_y;
    logic [COLOR_DEPTH-1:0] px_color;
    logic [Z_DEPTH-1:0]     px_z;
`else
    assign o_fb_horiz_read_addr = '0;
    assign o_fb_vert_read_addr  = '0;
    assign o_z_reject_count     = '0;
`endif

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state                 <= ST_IDLE;
            o_raster_in_progress  <= 1'b0;
            o_px_ready            <= 1'b0;
            o_fb_horiz_write_addr <= '0;
            o_fb_vert_write_addr  <= '0;
            o_fb_write_en         <= 1'b0;
            o_fb_write_pixel_data <= '0;
`ifdef GFG_FB_ZTEST_EN
            o_fb_horiz_read_addr  <= '0;
            o_fb_vert_read_addr   <= '0;
            o_z_reject_count      <= '0;
            px_x                  <= '0;
            px_y                  <= '0;
            px_color              <= '0;
            px_z                  <= '0;
`endif
        end else begin
            o_fb_write_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_new_frame) begin
                        // First clear write goes out with the state change.
                        state                 <= ST_CLEAR;
                        o_raster_in_progress  <= 1'b1;
                        o_fb_write_en         <= 1'b1;
                        o_fb_horiz_write_addr <= '0;
                        o_fb_vert_write_addr  <= '0;
                        o_fb_write_pixel_data <= {{Z_DEPTH{1'b1}}, CLEAR_COLOR};
`ifdef GFG_FB_ZTEST_EN
                        o_z_reject_count      <= '0;
`endif
                    end
                end
                ST_CLEAR: begin
                    if (scan_last) begin
                        state      <= ST_DRAW;
                        o_px_ready <= 1'b1;
                    end else begin
                        o_fb_write_en         <= 1'b1;
                        o_fb_horiz_write_addr <= scan_nx;
                        o_fb_vert_write_addr  <= scan_ny;
                    end
                end
                ST_DRAW: begin
                    if (i_px_valid) begin
                        if (px_in_range) begin
`ifdef GFG_FB_ZTEST_EN
                            state                <= ST_RD;
                            o_px_ready           <= 1'b0;
                            o_fb_horiz_read_addr <= i_px_x;
                            o_fb_vert_read_addr  <= i_px_y;
                            px_x                 <= i_px_x;
                            px_y                 <= i_px_y;
                            px_color             <= i_px_color;
                            px_z                 <= i_px_z;
`else
                            o_fb_write_en         <= 1'b1;
                            o_fb_horiz_write_addr <= i_px_x;
                            o_fb_vert_write_addr  <= i_px_y;
                            o_fb_write_pixel_data <= {i_px_z, i_px_color};
`endif
                        end
                    end else if (i_frame_done) begin
                        state                <= ST_IDLE;
                        o_px_ready           <= 1'b0;
                        o_raster_in_progress <= 1'b0;
                    end
                end
`ifdef GFG_FB_ZTEST_EN
                ST_RD: state <= ST_CMP;
                ST_CMP: begin
                    state      <= ST_DRAW;
                    o_px_ready <= 1'b1;
                    if (px_z <= i_fb_read_pixel_data[FBW-1 -: Z_DEPTH]) begin
                        o_fb_write_en         <= 1'b1;
                        o_fb_horiz_write_addr <= px_x;
                        o_fb_vert_write_addr  <= px_y;
                        o_fb_write_pixel_data <= {px_z, px_color};
                    end else if (o_z_reject_count != 16'hFFFF) begin
                        o_z_reject_count <= o_z_reject_count + 16'd1;
                    end
                end
`endif
                default: begin
                    state                <= ST_IDLE;
                    o_px_ready           <= 1'b0;
                    o_raster_in_progress <= 1'b0;
                end
            endcase
        end
    end

endmodule
